// File: rtl/cv32e40p_ro_mon_pkg.sv
// Shared types and defaults for the ring-oscillator clock monitor.
// Imported by the monitor top and its edge-sync helper.
package cv32e40p_ro_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    CHECK
  } ro_mon_state_e;

  localparam int unsigned RO_WINDOW_CYCLES = 256;
  localparam int unsigned RO_SETTLE_CYCLES = 8;
  localparam int unsigned RO_FAIL_THRESH   = 2;

  function automatic int unsigned ro_max(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cv32e40p_ro_sync_edge.sv
// Two-flop synchroniser plus rising-edge detect for async inputs.
// rise_o is a one-cycle pulse per synchronised low-to-high transition.
module cv32e40p_ro_sync_edge
  import cv32e40p_ro_mon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cv32e40p_ro_clk_monitor.sv
// Counts RO edges per fixed clk window and raises a sticky alarm
// after FAIL_THRESH consecutive out-of-bounds windows.
module cv32e40p_ro_clk_monitor
  import cv32e40p_ro_mon_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WINDOW_CYCLES = RO_WINDOW_CYCLES,
  parameter int unsigned SETTLE_CYCLES = RO_SETTLE_CYCLES,
  parameter int unsigned FAIL_THRESH   = RO_FAIL_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             ro_i,
  output logic             ro_en_o,
  input  logic [CNT_W-1:0] cnt_min_i,
  input  logic [CNT_W-1:0] cnt_max_i,
  output logic [CNT_W-1:0] last_count_o,
  output logic             meas_valid_o,
  output logic             alarm_o
);

  localparam int unsigned CYC_MAX =
    ro_max(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam int unsigned CYC_W  = $clog2(CYC_MAX);
  localparam int unsigned FAIL_W = $clog2(FAIL_THRESH + 1);

  localparam logic [CYC_W-1:0] WIN_END =
    CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [CYC_W-1:0] SET_END =
    CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_SAT =
    FAIL_W'(FAIL_THRESH);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  ro_mon_state_e     state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [FAIL_W-1:0] fail_nx;
  logic [CNT_W-1:0]  last_q, last_d;
  logic              valid_q, valid_d;
  logic              alarm_q, alarm_d;
  logic              rise;
  logic              in_range;
  logic              reach;

  cv32e40p_ro_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ro_i),
    .rise_o (rise)
  );

  assign in_range = (edge_q >= cnt_min_i) &&
                    (edge_q <= cnt_max_i);
  assign fail_nx  = (fail_q == FAIL_SAT) ? FAIL_SAT
                  : fail_q + FAIL_W'(1);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    edge_d  = edge_q;
    fail_d  = fail_q;
    last_d  = last_q;
    valid_d = 1'b0;
    alarm_d = alarm_q;
    reach   = 1'b0;

    if (state_q != IDLE && !enable_i) begin
      // Abort: the partial window is thrown away.
      state_d = IDLE;
      fail_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_d = SETTLE;
            cyc_d   = '0;
          end
        end
        SETTLE: begin
          if (cyc_q == SET_END) begin
            state_d = MEASURE;
            cyc_d   = '0;
            edge_d  = '0;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        MEASURE: begin
          if (rise && edge_q != CNT_SAT) begin
            edge_d = edge_q + CNT_W'(1);
          end
          if (cyc_q == WIN_END) begin
            state_d = CHECK;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        CHECK: begin
          last_d  = edge_q;
          valid_d = 1'b1;
          if (in_range) begin
            fail_d = '0;
          end else begin
            fail_d = fail_nx;
            reach  = (fail_nx == FAIL_SAT);
          end
          state_d = MEASURE;
          cyc_d   = '0;
          edge_d  = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A threshold hit beats a simultaneous clear.
    if (reach) begin
      alarm_d = 1'b1;
    end else if (clear_i) begin
      alarm_d = 1'b0;
      fail_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      edge_q  <= '0;
      fail_q  <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      edge_q  <= edge_d;
      fail_q  <= fail_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      alarm_q <= alarm_d;
    end
  end

  assign ro_en_o      = (state_q != IDLE);
  assign last_count_o = last_q;
  assign meas_valid_o = valid_q;
  assign alarm_o      = alarm_q;

endmodule

// File: doc/cv32e40p_ro_clk_monitor.md
Name: cv32e40p_ro_clk_monitor

Overview:
- Consumes the free-running ring-oscillator output and uses it as an independent timing reference against the core clock, to detect clock-injection and overclock attacks.
- Counts synchronised RO rising edges over a fixed window of clk cycles and compares the count against programmable bounds.
- Raises a sticky alarm after FAIL_THRESH consecutive out-of-bounds windows.
- Drives the RO enable. Sits between the RO macro and the core's security/alert logic.

Parameters:
- CNT_W, 16, width of edge counter, bounds and last_count_o.
- WINDOW_CYCLES, 256, clk cycles per measurement window (>=4).
- SETTLE_CYCLES, 8, clk cycles after RO enable before the first window (>=3, covers synchroniser fill).
- FAIL_THRESH, 2, consecutive failing windows needed to set the alarm (>=1).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- enable_i  input  1  monitor enable, level.
- clear_i  input  1  one-cycle pulse; clears alarm_o and the fail counter.
- ro_i  input  1  RO output, asynchronous to clk; frequency <= clk/4.
- ro_en_o  output  1  RO enable, driven to the RO en input.
- cnt_min_i  input  CNT_W  inclusive lower bound, quasi-static.
- cnt_max_i  input  CNT_W  inclusive upper bound, quasi-static.
- last_count_o  output  CNT_W  edge count of the most recent completed window.
- meas_valid_o  output  1  one-cycle pulse when last_count_o updates.
- alarm_o  output  1  sticky glitch alarm.

Behaviour:
- Reset values (async assert, sync deassert handled upstream):
  - All outputs 0.
  - FSM in IDLE; synchroniser, counters and fail counter all 0.
- ro_i path:
  - 2-flop synchroniser, then a third flop for edge detection.
  - rise = sync2 & ~sync3. Only rising edges are counted.
- FSM states: IDLE, SETTLE, MEASURE, CHECK.
  - IDLE: ro_en_o=0. enable_i=1 -> SETTLE, cycle counter cleared.
  - SETTLE: ro_en_o=1. After SETTLE_CYCLES cycles -> MEASURE with edge counter=0 and cycle counter=0.
  - MEASURE: ro_en_o=1.
    - Each cycle with rise=1 increments the edge counter, saturating at 2^CNT_W-1.
    - After exactly WINDOW_CYCLES cycles in MEASURE -> CHECK.
  - CHECK (one cycle): last_count_o <= edge count; meas_valid_o=1 during this cycle's following register stage (pulse appears the cycle after CHECK).
    - In range (cnt_min_i <= count <= cnt_max_i): fail counter=0.
    - Out of range: fail counter increments, saturating at FAIL_THRESH. Reaching FAIL_THRESH sets alarm_o.
    - Next state: MEASURE, edge counter cleared, no re-settle, RO stays enabled.
- Window length is fixed:
  - The edge sampled in the CHECK cycle is dropped.
  - Synchroniser latency makes the count ±1 edge; the bounds must absorb this.
- enable_i deasserted in any state except IDLE:
  - Next cycle -> IDLE with ro_en_o=0.
  - The window in progress is discarded: no meas_valid_o, fail counter cleared.
  - alarm_o and last_count_o are held.
- alarm_o:
  - Sticky until clear_i or reset. It is not cleared by enable_i.
  - clear_i in the same cycle as a CHECK that reaches FAIL_THRESH: set wins, alarm_o stays 1, fail counter = FAIL_THRESH.
  - clear_i at any other time: alarm_o=0 and fail counter=0 next cycle.
- cnt_min_i > cnt_max_i: every window fails, by design.
- A stuck ro_i (0 edges) fails whenever cnt_min_i > 0.

Decomposition:
- Package cv32e40p_ro_mon_pkg holds:
  - the FSM state enum ro_mon_state_e {IDLE, SETTLE, MEASURE, CHECK};
  - localparam defaults for WINDOW_CYCLES, SETTLE_CYCLES and FAIL_THRESH.
- One sub-module: cv32e40p_ro_sync_edge, containing the 2-flop synchroniser plus the rising-edge detector, with async active-low reset. It is reused for other async security inputs.

Test Plan:
1. Nominal lock: WINDOW_CYCLES=64, SETTLE=8, ro_i period 8 clk, bounds 6..10. The first meas_valid_o pulse comes 8+64+2 cycles after enable_i rises, with last_count_o=8. alarm_o stays 0 for 10 windows.
2. Clock-injection emulation: switch ro_i to period 16 (count 4) for two windows with FAIL_THRESH=2. alarm_o rises the cycle after the second CHECK. alarm_o stays 1 after ro_i returns to period 8.
3. Single glitch window: one window counts 4, then nominal. alarm_o stays 0 and the fail counter is back to 0 after the good window.
4. Clear and set race: pulse clear_i in the cycle of the second failing CHECK -> alarm_o=1. Pulse clear_i again in a later idle cycle -> alarm_o=0.
5. Abort: drop enable_i mid-MEASURE at cycle 30. ro_en_o=0 next cycle, no meas_valid_o, last_count_o unchanged. Re-enabling repeats SETTLE.
6. Reset and saturation:
   - CNT_W=3 with 8 edges per window: last_count_o=7 (saturated), fails with bounds 6..6.
   - Assert rst_n=0 mid-window: all outputs 0 immediately, including alarm_o.
